// File: rtl/img_in_loader.sv
// img_in_loader: buffers an input byte stream in a small FIFO and writes
// it to the image-input RAM port A at base_addr, base_addr+1, ...
// Each write waits for the RAM's d_ready_we pulse. A missing pulse
// aborts the load after TIMEOUT wait cycles.
// Optional build macro LOADER_READBACK_EN: each byte is read back and
// compared after its write (verify_err). When undefined, verify_err = 0.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start/base_addr/length   load request (ignored while busy)
//   in_data/in_valid/in_ready  byte stream in
//   mem_addr/mem_data/mem_we   RAM port A write side
//   mem_q/mem_d_ready_we/re    RAM port A read data and ready pulses
//   busy/done/count            load status
//   timeout_err/verify_err     sticky errors, cleared by next start
module img_in_loader #(
  parameter int         ADDR_W     = 19,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] TIMEOUT    = 8'd32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  input  logic [7:0]        mem_q,
  input  logic              mem_d_ready_we,
  input  logic              mem_d_ready_re,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  output logic              timeout_err,
  output logic              verify_err
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_SETUP   = 3'd2,
    S_WRITE   = 3'd3,
    S_WAIT_WE = 3'd4,
    S_DONE    = 3'd5
`ifdef LOADER_READBACK_EN
    , S_VERIFY = 3'd6
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        fifo_d [FIFO_DEPTH];
  logic [PW:0]       wr_q, wr_d;
  logic [PW:0]       rd_q, rd_d;
  logic              empty, full, push, pop, flush;
  logic              adv, fin;
  logic [ADDR_W-1:0] cnt_inc;

`ifdef LOADER_READBACK_EN
  logic verr_q, verr_d;
`endif

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) &&
                   (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign push    = in_valid & in_ready;
  assign cnt_inc = count_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
`ifdef LOADER_READBACK_EN
    verr_d  = verr_q;
`endif
    pop     = 1'b0;
    flush   = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          count_d = '0;
          terr_d  = 1'b0;
`ifdef LOADER_READBACK_EN
          verr_d  = 1'b0;
`endif
          busy_d  = 1'b1;
          state_d = (length == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = fifo_q[rd_q[PW-1:0]];
          addr_d  = base_q + count_q;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_WRITE;
      S_WRITE: begin
        wait_d  = '0;
        state_d = S_WAIT_WE;
      end
      S_WAIT_WE: begin
        if (mem_d_ready_we) begin
`ifdef LOADER_READBACK_EN
          wait_d  = '0;
          state_d = S_VERIFY;
`else
          adv = 1'b1;
`endif
        end else if (wait_q == TIMEOUT - 8'd1) begin
          terr_d = 1'b1;
          fin    = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
`ifdef LOADER_READBACK_EN
      S_VERIFY: begin
        if (mem_d_ready_re) begin
          if (mem_q != data_q) verr_d = 1'b1;
          adv = 1'b1;
        end else if (wait_q == TIMEOUT - 8'd1) begin
          terr_d = 1'b1;
          fin    = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
`endif
      S_DONE: begin
        // A load that ends here straight from IDLE (length 0) still
        // owes its done pulse; other paths pulsed on the way in.
        done_d  = busy_q;
        busy_d  = 1'b0;
        flush   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      count_d = cnt_inc;
      if (cnt_inc == len_q) fin = 1'b1;
      else state_d = S_FETCH;
    end
    if (fin) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = S_DONE;
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    wr_d   = wr_q + (PW+1)'(push);
    rd_d   = rd_q + (PW+1)'(pop);
    if (push) fifo_d[wr_q[PW-1:0]] = in_data;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef LOADER_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) verr_q <= 1'b0;
    else     verr_q <= verr_d;
  end
  assign verify_err = verr_q;
`else
  logic unused_rb;
  assign unused_rb  = ^{mem_q, mem_d_ready_re};
  assign verify_err = 1'b0;
`endif

  assign in_ready    = busy_q & ~full;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign mem_we      = (state_q == S_WRITE);
  assign busy        = busy_q;
  assign done        = done_q;
  assign count       = count_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_img_in_loader.sv
// tb_img_in_loader: directed bench for img_in_loader with a
// behavioural RAM model providing d_ready_we latency.
module tb_img_in_loader;

  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr, length;
  logic [7:0]    in_data;
  logic          in_valid, in_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data, mem_q;
  logic          mem_we, rdy_we, rdy_re;
  logic          busy, done, timeout_err, verify_err;
  logic [AW-1:0] count;

  img_in_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_q(mem_q), .mem_d_ready_we(rdy_we), .mem_d_ready_re(rdy_re),
    .busy(busy), .done(done), .count(count),
    .timeout_err(timeout_err), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM model and monitors, all evaluated on the falling edge.
  logic [7:0]    ram [int];
  logic [AW-1:0] alog [$];
  logic [7:0]    bytes [16];
  int lat_cnt = 0, nwr = 0, first_lat = 8, seq_lat = 2;
  int sup_after = 1000, cyc = 0, we_cnt = 0, done_cnt = 0;
  int last_rdy_cyc = 0, done_cyc = 0, we_cyc = 0, done_busy_bad = 0;
  bit stall_seen = 0;

  function automatic logic [7:0] rd(input int a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  assign rdy_re = 1'b0;

  initial begin
    rdy_we = 1'b0;
    mem_q  = 8'h00;
  end

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) done_busy_bad++;
    end
    if (busy && !in_ready) stall_seen = 1;
    if (rst) begin
      lat_cnt = 0;
      rdy_we  = 1'b0;
    end else if (mem_we) begin
      ram[int'(mem_addr)] = mem_data;
      alog.push_back(mem_addr);
      we_cnt++;
      we_cyc  = cyc;
      lat_cnt = (nwr == 0) ? first_lat : seq_lat;
      if (nwr >= sup_after) lat_cnt = 0;
      nwr++;
      rdy_we  = 1'b0;
    end else if (lat_cnt > 0) begin
      rdy_we = (lat_cnt == 1);
      if (lat_cnt == 1) last_rdy_cyc = cyc;
      lat_cnt--;
    end else begin
      rdy_we = 1'b0;
    end
    mem_q = rd(int'(mem_addr));
  end

  task automatic start_load(input logic [AW-1:0] b,
                            input logic [AW-1:0] l);
    @(negedge clk);
    nwr = 0; we_cnt = 0; done_cnt = 0;
    alog.delete();
    base_addr = b; length = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    int i = 0;
    int g = 0;
    while (i < n && g < 2000) begin
      in_valid = 1'b1;
      in_data  = bytes[i];
      if (in_ready) i++;
      g++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("feed_to", i, n);
  endtask

  task automatic wait_done(input int lim);
    int g = 0;
    while (done_cnt == 0 && g < lim) begin
      @(negedge clk); #1;
      g++;
    end
    chk("done_to", (g < lim), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", count, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_verr", verify_err, 0);
    rst = 1'b0;

    // basic load
    first_lat = 8; seq_lat = 2;
    bytes[0] = 8'hA0; bytes[1] = 8'hA1;
    bytes[2] = 8'hA2; bytes[3] = 8'hA3;
    start_load(19'h00003, 19'd4);
    chk("bas_busy", busy, 1);
    chk("bas_rdy", in_ready, 1);
    fork
      feed(4);
      wait_done(300);
    join
    for (int i = 0; i < 4; i++)
      chk($sformatf("bas_ram%0d", i), rd(3 + i), 8'hA0 + i);
    chk("bas_cnt", count, 4);
    chk("bas_we", we_cnt, 4);
    chk("bas_done", done_cnt, 1);
    chk("bas_terr", timeout_err, 0);
    chk("bas_lat", done_cyc - last_rdy_cyc, 1);

    // zero length
    start_load(19'h00010, 19'd0);
    chk("zl_busy", busy, 1);
    chk("zl_rdy1", in_ready, 1);
    chk("zl_done1", done, 0);
    @(negedge clk);
    chk("zl_done2", done, 1);
    chk("zl_rdy2", in_ready, 0);
    chk("zl_busy2", busy, 0);
    @(negedge clk);
    chk("zl_done3", done, 0);
    chk("zl_we", we_cnt, 0);

    // backpressure
    seq_lat = 1; stall_seen = 0;
    for (int i = 0; i < 10; i++) bytes[i] = 8'h50 + 8'(i);
    start_load(19'h00100, 19'd10);
    fork
      feed(10);
      wait_done(600);
    join
    chk("bp_stall", stall_seen, 1);
    chk("bp_cnt", count, 10);
    chk("bp_we", we_cnt, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("bp_ram%0d", i), rd(32'h100 + i), 8'h50 + i);

    // address wrap
    seq_lat = 3;
    bytes[0] = 8'h61; bytes[1] = 8'h62; bytes[2] = 8'h63;
    start_load(19'h7FFFE, 19'd3);
    fork
      feed(3);
      wait_done(300);
    join
    chk("wr_n", alog.size(), 3);
    if (alog.size() == 3) begin
      chk("wr_a0", alog[0], 32'h7FFFE);
      chk("wr_a1", alog[1], 32'h7FFFF);
      chk("wr_a2", alog[2], 32'h00000);
    end
    chk("wr_ram", rd(0), 8'h63);
    chk("wr_cnt", count, 3);

    // timeout on the third byte
    seq_lat = 2; sup_after = 2;
    for (int i = 0; i < 4; i++) bytes[i] = 8'h71 + 8'(i);
    start_load(19'h00200, 19'd4);
    fork
      feed(4);
      wait_done(600);
    join
    chk("to_terr", timeout_err, 1);
    chk("to_cnt", count, 2);
    chk("to_we", we_cnt, 3);
    chk("to_done", done_cnt, 1);
    chk("to_wait", done_cyc - we_cyc, 33);
    chk("to_busy", busy, 0);

    // next start clears the error; leftover byte must be gone
    sup_after = 1000;
    bytes[0] = 8'hC5;
    start_load(19'h00300, 19'd1);
    chk("clr_terr", timeout_err, 0);
    fork
      feed(1);
      wait_done(300);
    join
    chk("clr_ram", rd(32'h300), 8'hC5);
    chk("clr_cnt", count, 1);
    chk("clr_terr2", timeout_err, 0);

    // reset during WAIT_WE
    first_lat = 8;
    bytes[0] = 8'h81; bytes[1] = 8'h82; bytes[2] = 8'h83;
    start_load(19'h00400, 19'd3);
    feed(3);
    #1;
    begin
      int g = 0;
      while (we_cnt == 0 && g < 50) begin
        @(negedge clk); #1;
        g++;
      end
      chk("mr_we_to", (g < 50), 1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_we", mem_we, 0);
    chk("mr_rdy", in_ready, 0);
    chk("mr_done", done, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("mr_nodone", done_cnt, 0);
    chk("mr_we_n", we_cnt, 1);
    chk("done_busy", done_busy_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
